// File: rtl/axis_snoop_rr_arb.sv
// Packet-level round-robin arbiter: merges up to four AXI-Stream snoop FIFO outputs
// onto one master port, holding each grant from the first beat through tlast.
module axis_snoop_rr_arb #(
  parameter int NUM_CHANNELS = 4,
  parameter int PORT_WIDTH   = 8,
  parameter int MAX_BEATS    = 256,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    axis_aclk,
  input  logic                    axis_aresetn,
  input  logic [3:0]              s_axis_tvalid,
  output logic [3:0]              s_axis_tready,
  input  logic [4*PORT_WIDTH-1:0] s_axis_tdata,
  input  logic [3:0]              s_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [PORT_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tlast,
  input  logic [3:0]              chan_enable,
  output logic                    busy,
  output logic [1:0]              grant_idx,
  output logic [4*CNT_WIDTH-1:0]  pkt_count,
  output logic [3:0]              trunc_err,
  input  logic                    clear_stats
);

  localparam int BCW = $clog2(MAX_BEATS);
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(MAX_BEATS - 1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [1:0]             r_rr_ptr;
  logic [1:0]             r_grant_idx;
  logic [BCW-1:0]         r_beat_cnt;
  logic [CNT_WIDTH-1:0]   r_pkt_count [4];
  logic [3:0]             r_trunc_err;

  logic [3:0]             w_req;
  logic                   w_found;
  logic [1:0]             w_pick;
  logic [1:0]             w_rr_nxt;
  logic                   w_beat;
  logic                   w_eop;

  // Handshake: a beat moves on any cycle where tvalid and tready are both 1; the
  // granted source sees m_axis_tready directly, every other source sees tready=0.

  always_comb begin
    w_req = '0;
    for (int i = 0; i < 4; i++) begin
      w_req[i] = s_axis_tvalid[i] & chan_enable[i] & (i < NUM_CHANNELS);
    end
  end

  // Scan from the round-robin pointer, wrapping within the active channels only.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_pick  = 2'd0;
    idx     = 0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      idx = (int'(r_rr_ptr) + k) % NUM_CHANNELS;
      if (!w_found && w_req[idx]) begin
        w_found = 1'b1;
        w_pick  = 2'(idx);
      end
    end
  end

  assign w_rr_nxt = (int'(r_grant_idx) == NUM_CHANNELS - 1) ? 2'd0 : r_grant_idx + 2'd1;

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    busy          = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = 4'b0000;
    w_beat        = 1'b0;
    w_eop         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) w_state_nxt = S_GRANT;
      end
      S_GRANT: begin
        busy          = 1'b1;
        m_axis_tvalid = s_axis_tvalid[r_grant_idx];
        m_axis_tdata  = s_axis_tdata[int'(r_grant_idx)*PORT_WIDTH +: PORT_WIDTH];
        // Forced tlast caps the packet length even if the source never ends it.
        m_axis_tlast  = s_axis_tlast[r_grant_idx] | (r_beat_cnt == LAST_BEAT);
        s_axis_tready = 4'(m_axis_tready) << r_grant_idx;
        w_beat        = s_axis_tvalid[r_grant_idx] & m_axis_tready;
        w_eop         = w_beat & m_axis_tlast;
        if (w_eop) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      r_grant_idx <= 2'd0;
      r_rr_ptr    <= 2'd0;
      r_beat_cnt  <= '0;
    end else begin
      if (r_state == S_IDLE && w_found) r_grant_idx <= w_pick;
      if (w_eop) begin
        r_beat_cnt <= '0;
        r_rr_ptr   <= w_rr_nxt;
      end else if (w_beat) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
    end
  end

  // Statistics; a same-cycle clear overrides any increment or sticky set.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      for (int i = 0; i < 4; i++) r_pkt_count[i] <= '0;
      r_trunc_err <= 4'b0000;
    end else if (clear_stats) begin
      for (int i = 0; i < 4; i++) r_pkt_count[i] <= '0;
      r_trunc_err <= 4'b0000;
    end else if (w_eop) begin
      r_pkt_count[r_grant_idx] <= r_pkt_count[r_grant_idx] + 1'b1;
      if (!s_axis_tlast[r_grant_idx]) r_trunc_err[r_grant_idx] <= 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) pkt_count[i*CNT_WIDTH +: CNT_WIDTH] = r_pkt_count[i];
  end

  assign grant_idx = r_grant_idx;
  assign trunc_err = r_trunc_err;

endmodule
